// File: rtl/stack_unit.sv
// LIFO stack, DEPTH x WIDTH register array with top/next-on-stack read ports and sticky error flags.
// Latency: an operation presented in cycle n is visible on tos/nos/count/empty/full/ack in cycle n+1.
// Backpressure: none; refused operations (push when full, pop when empty) are dropped and flagged via ovf/unf.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   push, pop, din     operation strobes and push data (push & pop together replaces the top entry)
//   err_clr            clears ovf/unf at the next edge; a concurrent new error still sets its flag
//   tos, nos           top and next-on-stack entries, 0 when not valid
//   count, empty, full occupancy, 0..DEPTH
//   ack                one-cycle pulse after each accepted operation
//   ovf, unf           sticky overflow / underflow flags
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ack,
    output logic             ovf,
    output logic             unf
);

    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] TWO     = (AW+1)'(2);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Storage is never reset; only entries below count are observable.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0] count_q, count_d;
    logic        ack_q,   ack_d;
    logic        ovf_q,   ovf_d;
    logic        unf_q,   unf_d;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW:0]   top_ptr;
    logic [AW:0]   nxt_ptr;
    logic          is_empty;
    logic          is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign top_ptr  = count_q - ONE;
    assign nxt_ptr  = count_q - TWO;

    always_comb begin
        count_d = count_q;
        ack_d   = 1'b0;
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        wr_en   = 1'b0;
        wr_idx  = count_q[AW-1:0];

        if (push && !pop) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                wr_idx  = count_q[AW-1:0];
                count_d = count_q + ONE;
                ack_d   = 1'b1;
            end else begin
                ovf_d = 1'b1;   // set wins over err_clr
            end
        end else if (pop && !push) begin
            if (!is_empty) begin
                count_d = top_ptr;
                ack_d   = 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end else if (push && pop) begin
            // Replace-top keeps count unchanged, so it is legal even when full.
            if (!is_empty) begin
                wr_en  = 1'b1;
                wr_idx = top_ptr[AW-1:0];
                ack_d  = 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end

        // Reset overrides any concurrent operation and error event.
        if (rst) begin
            count_d = '0;
            ack_d   = 1'b0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign tos   = is_empty          ? '0 : mem_q[top_ptr[AW-1:0]];
    assign nos   = (count_q < TWO)   ? '0 : mem_q[nxt_ptr[AW-1:0]];
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ack   = ack_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit (DEPTH=4, WIDTH=8): directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             ack;
    logic             ovf;
    logic             unf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [WIDTH-1:0] stk[$];
    logic             m_ack = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
        .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
        .ack(ack), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply the rules of one edge to the model, using the pre-edge state.
    task automatic model_edge(input logic r, input logic p, input logic po,
                              input logic [WIDTH-1:0] d, input logic ec);
        logic acc, oe, ue;
        acc = 1'b0; oe = 1'b0; ue = 1'b0;
        if (r) begin
            stk.delete();
            m_ack = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (p && !po) begin
                if (stk.size() < DEPTH) begin stk.push_back(d); acc = 1'b1; end
                else oe = 1'b1;
            end else if (po && !p) begin
                if (stk.size() > 0) begin void'(stk.pop_back()); acc = 1'b1; end
                else ue = 1'b1;
            end else if (p && po) begin
                if (stk.size() > 0) begin stk[stk.size()-1] = d; acc = 1'b1; end
                else ue = 1'b1;
            end
            m_ack = acc;
            m_ovf = oe | (m_ovf & ~ec);
            m_unf = ue | (m_unf & ~ec);
        end
    endtask

    function automatic logic [WIDTH-1:0] m_tos();
        return (stk.size() > 0) ? stk[stk.size()-1] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_nos();
        return (stk.size() > 1) ? stk[stk.size()-2] : '0;
    endfunction

    task automatic check_all();
        chk("tos",   32'(tos),   32'(m_tos()));
        chk("nos",   32'(nos),   32'(m_nos()));
        chk("count", 32'(count), 32'(stk.size()));
        chk("empty", 32'(empty), 32'(stk.size() == 0));
        chk("full",  32'(full),  32'(stk.size() == DEPTH));
        chk("ack",   32'(ack),   32'(m_ack));
        chk("ovf",   32'(ovf),   32'(m_ovf));
        chk("unf",   32'(unf),   32'(m_unf));
    endtask

    // Drive one cycle: inputs set at negedge, model stepped at posedge, outputs sampled 1 time unit later.
    task automatic do_op(input logic r, input logic p, input logic po,
                         input logic [WIDTH-1:0] d, input logic ec);
        @(negedge clk);
        rst = r; push = p; pop = po; din = d; err_clr = ec;
        @(posedge clk);
        model_edge(r, p, po, d, ec);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        do_op(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        do_op(1'b0, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic do_pop();
        do_op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset state
        do_reset();
        do_reset();
        chk("rst_tos", 32'(tos), 0);
        chk("rst_nos", 32'(nos), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);

        // Three consecutive pushes give continuous ack
        do_push(8'h11); chk("p1_ack", 32'(ack), 1);
        do_push(8'h22); chk("p2_ack", 32'(ack), 1);
        do_push(8'h33); chk("p3_ack", 32'(ack), 1);
        chk("p3_tos", 32'(tos), 32'h33);
        chk("p3_nos", 32'(nos), 32'h22);
        chk("p3_count", 32'(count), 3);

        // Overflow at full, then clear
        do_push(8'h44);
        chk("fill_full", 32'(full), 1);
        do_push(8'h55);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_ack", 32'(ack), 0);
        chk("ovf_tos", 32'(tos), 32'h44);
        do_op(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_clr", 32'(ovf), 0);

        // Replace-top when full is legal
        do_op(1'b0, 1'b1, 1'b1, 8'h66, 1'b0);
        chk("rep_full_tos", 32'(tos), 32'h66);
        chk("rep_full_ack", 32'(ack), 1);

        // Underflow from empty; set wins over err_clr
        do_reset();
        do_pop();
        chk("unf_flag", 32'(unf), 1);
        chk("unf_count", 32'(count), 0);
        chk("unf_ack", 32'(ack), 0);
        do_op(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("unf_setwins", 32'(unf), 1);
        do_op(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        chk("pp_empty_unf", 32'(unf), 1);
        chk("pp_empty_count", 32'(count), 0);

        // Push and pop together replaces the top
        do_reset();
        do_push(8'h11);
        do_push(8'h22);
        do_op(1'b0, 1'b1, 1'b1, 8'h99, 1'b0);
        chk("rep_count", 32'(count), 2);
        chk("rep_tos", 32'(tos), 32'h99);
        chk("rep_nos", 32'(nos), 32'h11);
        chk("rep_ack", 32'(ack), 1);

        // Push two, pop two
        do_reset();
        do_push(8'hAA);
        do_push(8'hBB);
        do_pop();
        chk("pop1_tos", 32'(tos), 32'hAA);
        chk("pop1_nos", 32'(nos), 0);
        do_pop();
        chk("pop2_tos", 32'(tos), 0);
        chk("pop2_empty", 32'(empty), 1);
        chk("pop2_nos", 32'(nos), 0);

        // Reset overrides concurrent push
        do_reset();
        do_push(8'h11);
        do_push(8'h22);
        do_push(8'h33);
        do_op(1'b1, 1'b1, 1'b0, 8'h88, 1'b0);
        chk("rstop_count", 32'(count), 0);
        chk("rstop_tos", 32'(tos), 0);
        chk("rstop_ack", 32'(ack), 0);
        do_push(8'h44);
        chk("rstop_push_tos", 32'(tos), 32'h44);
        chk("rstop_push_count", 32'(count), 1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic r, p, po, ec;
            logic [WIDTH-1:0] d;
            r  = ($urandom_range(0, 39) == 0);
            p  = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            ec = ($urandom_range(0, 7) == 0);
            d  = WIDTH'($urandom);
            do_op(r, p, po, d, ec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
